load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-002 SHALL have port resetn, input, 1: asynchronous, active-low reset.
REQ-003 SHALL have port req_valid, input, 1: core access request.
REQ-004 SHALL have port req_ready, output, 1: the unit accepts the request; high only in IDLE.
REQ-005 SHALL have port req_we, input, 1: 1 means store, 0 means load.
REQ-006 SHALL have port req_funct3, input, 3: access type using RV32I encoding (000 B, 001 H, 010 W, 100 BU, 101 HU).
REQ-007 SHALL have port req_addr, input, 32: byte address.
REQ-008 SHALL have port req_wdata, input, 32: store data, taken from its least significant bits.
REQ-009 SHALL have port resp_valid, output, 1: one-cycle completion pulse.
REQ-010 SHALL have port resp_rdata, output, 32: aligned and extended load result; 0 for stores and errors.
REQ-011 SHALL have port resp_err, output, 1: qualifies resp_valid; the access is illegal and was not performed.
REQ-012 SHALL have ports mem_addr out 32, mem_rstrb out 1, mem_rdata in 32, mem_wdata out 32, mem_wmask out 4. This is the initiator side of the word memory. The memory reads mem[mem_addr[31:2]] and returns it on mem_rdata one clock after mem_rstrb.

Function
REQ-013 SHALL use a state machine with states IDLE, READ, DATA, WRITE, RESP.
REQ-014 In IDLE, req_valid SHALL be accepted, latching addr, funct3, we and wdata.
- Illegal funct3 (011, 11x, or 10x with we=1) SHALL go to RESP with resp_err=1.
- A legal load SHALL go to READ; a legal store SHALL go to WRITE.
REQ-015 In READ, mem_rstrb SHALL be 1 for exactly one cycle, with mem_addr = {addr[31:2],2'b00}. The next state SHALL be DATA.
REQ-016 In DATA, mem_rdata SHALL be aligned and extended, then registered into resp_rdata. The next state SHALL be RESP.
- Byte loads SHALL select lane addr[1:0]; halfword loads SHALL select lane addr[1].
- B and H SHALL sign-extend; BU and HU SHALL zero-extend; W SHALL pass the word unchanged.
REQ-017 In WRITE, mem_wmask SHALL be nonzero for exactly one cycle, then the next state SHALL be RESP.
- B: mask 4'b0001<<addr[1:0], mem_wdata = {4{wdata[7:0]}}.
- H: mask 4'b0011<<{addr[1],1'b0}, mem_wdata = {2{wdata[15:0]}}.
- W: mask 4'b1111, mem_wdata = wdata.
REQ-018 In RESP, resp_valid SHALL be 1 for one cycle, then the next state SHALL be IDLE.
REQ-019 Latency SHALL be fixed:
- Load: resp_valid high 4 cycles after the acceptance edge.
- Store: 3 cycles.
- Error: 2 cycles.
REQ-020 Outside READ, mem_rstrb SHALL be 0; outside WRITE, mem_wmask SHALL be 0. A single request SHALL never produce two strobes.
REQ-021 req_valid SHALL be ignored while not in IDLE; there is no queueing.
REQ-022 A request SHALL NOT be accepted in the same cycle as resp_valid; req_ready rises in the following cycle.

Reset
REQ-023 When resetn=0, the following SHALL hold asynchronously: state=IDLE, req_ready=1, resp_valid=0, resp_err=0, resp_rdata=0, mem_rstrb=0, mem_wmask=0, mem_addr=0, mem_wdata=0.
REQ-024 A reset asserted mid-operation SHALL abort the access without emitting a response or any later strobe.

Configuration
REQ-025 With MISALIGN_TRAP_EN defined, the following SHALL be treated as illegal (resp_err=1, no memory access): H/HU with addr[0]=1, and W with addr[1:0]!=0.
REQ-026 Without MISALIGN_TRAP_EN, the address low bits SHALL be ignored, forcing alignment: H uses addr[1] only; W ignores addr[1:0].

Structure
REQ-027 A shared package lsu_pkg SHALL hold the funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU) and the state enum.
REQ-028 Load extraction SHALL be a combinational sub-module load_align (inputs: word, addr[1:0], funct3; output: 32-bit result), reused by the core writeback.

Verification
REQ-029 With mem word 100 = 0x04030201: LB addr 401 -> resp_rdata 0x00000002, exactly one mem_rstrb, resp_valid 4 cycles after acceptance.
REQ-030 With mem word 103 = 0xff0f0e0d: LB 415 -> 0xffffffff; LBU 415 -> 0x000000ff; LH 414 -> 0xffffff0f; LHU 414 -> 0x0000ff0f; LW 412 -> 0xff0f0e0d.
REQ-031 SB addr 402 with wdata 0x123456AB -> mem_wmask 4'b0100, mem_wdata 0xABABABAB, one cycle; SW 400 -> mask 4'b1111.
REQ-032 funct3 011 load, and SBU (we=1, funct3 100) -> resp_err=1, resp_rdata 0, no mem_rstrb or mem_wmask, latency 2.
REQ-033 With MISALIGN_TRAP_EN, LW 401 -> resp_err=1. Without the macro, LW 401 -> 0x04030201.
REQ-034 Assert resetn=0 during DATA -> all outputs reach reset values immediately, no resp_valid. A new LW after release completes normally.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared load/store definitions: RV32I funct3 access codes, FSM states and request legality helpers.
package lsu_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      READ  = 3'd1,
      DATA  = 3'd2,
      WRITE = 3'd3,
      RESP  = 3'd4
   } lsu_state_e;

   // Unsigned variants only make sense for loads.
   function automatic logic f3_legal(input logic we, input logic [2:0] f3);
      case (f3)
         F3_B, F3_H, F3_W: return 1'b1;
         F3_BU, F3_HU:     return !we;
         default:          return 1'b0;
      endcase
   endfunction

   function automatic logic f3_misaligned(input logic [2:0] f3, input logic [1:0] a);
      return (((f3 == F3_H) || (f3 == F3_HU)) && a[0]) || ((f3 == F3_W) && (a != 2'b00));
   endfunction

endpackage

// File: rtl/load_align.sv
// Combinational load extraction: lane select plus sign/zero extension of a memory word.
module load_align
   import lsu_pkg::*;
(
   input  logic [31:0] word,
   input  logic [1:0]  addr,
   input  logic [2:0]  funct3,
   output logic [31:0] result
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;

   always_comb begin
      case (addr)
         2'd0:    w_byte = word[7:0];
         2'd1:    w_byte = word[15:8];
         2'd2:    w_byte = word[23:16];
         default: w_byte = word[31:24];
      endcase
      w_half = addr[1] ? word[31:16] : word[15:0];
   end

   always_comb begin
      case (funct3)
         F3_B:    result = {{24{w_byte[7]}}, w_byte};
         F3_BU:   result = {24'd0, w_byte};
         F3_H:    result = {{16{w_half[15]}}, w_half};
         F3_HU:   result = {16'd0, w_half};
         default: result = word;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit driving a word-wide memory with one-cycle read latency.
// Optional build macro MISALIGN_TRAP_EN: misaligned H/HU/W accesses return resp_err instead of forcing alignment.
module load_store_unit
   import lsu_pkg::*;
(
   input  logic        clk,
   input  logic        resetn,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   output logic [31:0] mem_addr,
   output logic        mem_rstrb,
   input  logic [31:0] mem_rdata,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_wmask
);

   lsu_state_e  r_state;
   lsu_state_e  w_next;
   logic [31:0] r_addr;
   logic [31:0] r_wdata;
   logic [31:0] r_rdata;
   logic [2:0]  r_f3;
   logic        r_we;
   logic        r_err;
   logic        w_accept;
   logic        w_legal;
   logic [31:0] w_aligned;

   assign w_accept = req_valid && (r_state == IDLE);

   always_comb begin
      w_legal = f3_legal(req_we, req_funct3);
`ifdef MISALIGN_TRAP_EN
      if (f3_misaligned(req_funct3, req_addr[1:0])) begin
         w_legal = 1'b0;
      end
`endif
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE: begin
            if (req_valid) begin
               if (!w_legal)    w_next = RESP;
               else if (req_we) w_next = WRITE;
               else             w_next = READ;
            end
         end
         READ:    w_next = DATA;
         DATA:    w_next = RESP;
         WRITE:   w_next = RESP;
         RESP:    w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state <= IDLE;
         r_addr  <= 32'd0;
         r_wdata <= 32'd0;
         r_rdata <= 32'd0;
         r_f3    <= 3'd0;
         r_we    <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_next;
         if (w_accept) begin
            r_addr  <= req_addr;
            r_wdata <= req_wdata;
            r_f3    <= req_funct3;
            r_we    <= req_we;
            r_err   <= !w_legal;
            r_rdata <= 32'd0;
         end else if (r_state == DATA) begin
            r_rdata <= w_aligned;
         end
      end
   end

   // Memory word arrives the cycle after the READ strobe, i.e. during DATA.
   load_align u_load_align (
      .word   (mem_rdata),
      .addr   (r_addr[1:0]),
      .funct3 (r_f3),
      .result (w_aligned)
   );

   assign req_ready  = (r_state == IDLE);
   assign resp_valid = (r_state == RESP);
   assign resp_err   = (r_state == RESP) && r_err;
   assign resp_rdata = r_rdata;
   assign mem_rstrb  = (r_state == READ);
   assign mem_addr   = {r_addr[31:2], 2'b00};

   always_comb begin
      mem_wmask = 4'b0000;
      case (r_f3[1:0])
         2'b00:   mem_wdata = {4{r_wdata[7:0]}};
         2'b01:   mem_wdata = {2{r_wdata[15:0]}};
         default: mem_wdata = r_wdata;
      endcase
      if ((r_state == WRITE) && r_we) begin
         case (r_f3[1:0])
            2'b00:   mem_wmask = 4'b0001 << r_addr[1:0];
            2'b01:   mem_wmask = 4'b0011 << {r_addr[1], 1'b0};
            default: mem_wmask = 4'b1111;
         endcase
      end
   end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: word memory, spec-level transaction model, per-cycle compare.
module tb_load_store_unit;

   logic        clk = 1'b0;
   logic        resetn;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic [31:0] mem_addr;
   logic        mem_rstrb;
   logic [31:0] mem_rdata;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_wmask;

   load_store_unit dut (
      .clk        (clk),
      .resetn     (resetn),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_we     (req_we),
      .req_funct3 (req_funct3),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .resp_valid (resp_valid),
      .resp_rdata (resp_rdata),
      .resp_err   (resp_err),
      .mem_addr   (mem_addr),
      .mem_rstrb  (mem_rstrb),
      .mem_rdata  (mem_rdata),
      .mem_wdata  (mem_wdata),
      .mem_wmask  (mem_wmask)
   );

   always #5 clk = ~clk;

   logic [31:0] env_mem   [0:255];
   logic [31:0] model_mem [0:255];

   // Memory seen by the DUT: read data one clock after the strobe, byte-masked writes.
   always @(posedge clk) begin
      if (mem_rstrb) mem_rdata <= env_mem[mem_addr[9:2]];
      for (int b = 0; b < 4; b++) begin
         if (mem_wmask[b]) env_mem[mem_addr[9:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
      end
   end

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
      end
   endtask

   localparam int K_LOAD = 0, K_STORE = 1, K_ERR = 2;

   bit          active  = 1'b0;
   bit          suspend = 1'b1;
   int          cyc;
   int          e_kind;
   int          e_lat;
   logic [31:0] e_rdata;
   logic        e_err;
   logic [3:0]  e_mask;
   logic [31:0] e_wdata;
   logic [31:0] e_maddr;

   function automatic logic model_legal(input logic we, input logic [2:0] f3, input logic [31:0] a);
      logic ok;
      ok = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) || (!we && ((f3 == 3'd4) || (f3 == 3'd5)));
`ifdef MISALIGN_TRAP_EN
      if (((f3 == 3'd1) || (f3 == 3'd5)) && a[0]) ok = 1'b0;
      if ((f3 == 3'd2) && (a[1:0] != 2'd0)) ok = 1'b0;
`endif
      return ok;
   endfunction

   function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a);
      logic [31:0] w;
      w = model_mem[a[9:2]];
      case (f3)
         3'd0, 3'd4: begin
            w = (w >> (8 * a[1:0])) & 32'hff;
            if ((f3 == 3'd0) && (w >= 32'd128)) w = w - 32'd256;
         end
         3'd1, 3'd5: begin
            w = (w >> (16 * a[1])) & 32'hffff;
            if ((f3 == 3'd1) && (w >= 32'd32768)) w = w - 32'd65536;
         end
         default: ;
      endcase
      return w;
   endfunction

   // Per-cycle compare against the expectation of the transaction in flight.
   always @(negedge clk) begin
      if (resetn && !suspend) begin
         if (active) begin
            cyc = cyc + 1;
            chk("ready_busy", {31'd0, req_ready}, 32'd0);
            chk("rstrb", {31'd0, mem_rstrb}, {31'd0, (e_kind == K_LOAD) && (cyc == 1)});
            chk("wmask", {28'd0, mem_wmask}, ((e_kind == K_STORE) && (cyc == 1)) ? {28'd0, e_mask} : 32'd0);
            if ((e_kind == K_LOAD) && (cyc == 1)) chk("mem_addr", mem_addr, e_maddr);
            if ((e_kind == K_STORE) && (cyc == 1)) chk("mem_wdata", mem_wdata, e_wdata);
            chk("resp_valid", {31'd0, resp_valid}, {31'd0, cyc == e_lat - 1});
            if (cyc == e_lat - 1) begin
               chk("resp_err", {31'd0, resp_err}, {31'd0, e_err});
               chk("resp_rdata", resp_rdata, e_rdata);
               active = 1'b0;
            end
         end else begin
            chk("idle_ready", {31'd0, req_ready}, 32'd1);
            chk("idle_valid", {31'd0, resp_valid}, 32'd0);
            chk("idle_strobes", {27'd0, mem_rstrb, mem_wmask}, 32'd0);
         end
      end
   end

   task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input bit hold, input bit use_lit,
                         input logic [31:0] lit_rdata, input logic lit_err, input logic [3:0] lit_mask);
      int          kind, lat;
      logic [31:0] m_rdata, m_wdata, w;
      logic [3:0]  m_mask;
      logic        m_err;
      m_rdata = 32'd0;
      m_mask  = 4'd0;
      m_wdata = 32'd0;
      m_err   = 1'b0;
      if (!model_legal(we, f3, a)) begin
         kind = K_ERR; lat = 2; m_err = 1'b1;
      end else if (we) begin
         kind = K_STORE; lat = 3;
         w = model_mem[a[9:2]];
         if (f3 == 3'd0) begin
            m_mask  = 4'(1 << a[1:0]);
            m_wdata = (wd & 32'hff) * 32'h01010101;
            w = (w & ~(32'hff << (8 * a[1:0]))) | ((wd & 32'hff) << (8 * a[1:0]));
         end else if (f3 == 3'd1) begin
            m_mask  = 4'(3 << (2 * a[1]));
            m_wdata = (wd & 32'hffff) * 32'h00010001;
            w = (w & ~(32'hffff << (16 * a[1]))) | ((wd & 32'hffff) << (16 * a[1]));
         end else begin
            m_mask  = 4'hf;
            m_wdata = wd;
            w = wd;
         end
         model_mem[a[9:2]] = w;
      end else begin
         kind = K_LOAD; lat = 4;
         m_rdata = model_load(f3, a);
      end
      if (use_lit) begin
         chk("model_rdata", m_rdata, lit_rdata);
         chk("model_err", {31'd0, m_err}, {31'd0, lit_err});
         chk("model_mask", {28'd0, m_mask}, {28'd0, lit_mask});
      end
      @(negedge clk);
      #1;
      req_valid  = 1'b1;
      req_we     = we;
      req_funct3 = f3;
      req_addr   = a;
      req_wdata  = wd;
      @(posedge clk);
      #1;
      e_kind  = kind;
      e_lat   = lat;
      e_rdata = m_rdata;
      e_err   = m_err;
      e_mask  = m_mask;
      e_wdata = m_wdata;
      e_maddr = {a[31:2], 2'b00};
      cyc     = 0;
      active  = 1'b1;
      if (hold) begin
         // Busy-time request that must be ignored, kept up through the response cycle.
         req_we     = 1'b1;
         req_funct3 = 3'd2;
         req_addr   = 32'd0;
         req_wdata  = 32'hffffffff;
      end else begin
         req_valid = 1'b0;
      end
      for (int i = 0; (i < 10) && active; i++) begin
         @(negedge clk);
         #1;
      end
      req_valid = 1'b0;
      if (active) begin
         chk("timeout", 32'd1, 32'd0);
         active = 1'b0;
      end
      if (we) chk("mem_word", env_mem[a[9:2]], model_mem[a[9:2]]);
   endtask

   initial begin
      for (int i = 0; i < 256; i++) begin
         env_mem[i]   = 32'd0;
         model_mem[i] = 32'd0;
      end
      env_mem[100] = 32'h04030201; model_mem[100] = 32'h04030201;
      env_mem[103] = 32'hff0f0e0d; model_mem[103] = 32'hff0f0e0d;
      resetn = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0;
      req_addr = 32'd0; req_wdata = 32'd0;
      #3;
      chk("rst_ready", {31'd0, req_ready}, 32'd1);
      chk("rst_valid", {31'd0, resp_valid}, 32'd0);
      chk("rst_err", {31'd0, resp_err}, 32'd0);
      chk("rst_rdata", resp_rdata, 32'd0);
      chk("rst_strobes", {27'd0, mem_rstrb, mem_wmask}, 32'd0);
      chk("rst_maddr", mem_addr, 32'd0);
      chk("rst_wdata", mem_wdata, 32'd0);
      repeat (2) @(negedge clk);
      #1;
      resetn  = 1'b1;
      suspend = 1'b0;

      do_req(1'b0, 3'd0, 32'd401, 32'd0, 1'b0, 1'b1, 32'h00000002, 1'b0, 4'h0);
`ifdef MISALIGN_TRAP_EN
      do_req(1'b0, 3'd2, 32'd401, 32'd0, 1'b0, 1'b1, 32'h00000000, 1'b1, 4'h0);
      do_req(1'b0, 3'd1, 32'd401, 32'd0, 1'b0, 1'b1, 32'h00000000, 1'b1, 4'h0);
`else
      do_req(1'b0, 3'd2, 32'd401, 32'd0, 1'b0, 1'b1, 32'h04030201, 1'b0, 4'h0);
      do_req(1'b0, 3'd1, 32'd401, 32'd0, 1'b0, 1'b1, 32'h00000201, 1'b0, 4'h0);
`endif
      do_req(1'b0, 3'd0, 32'd415, 32'd0, 1'b0, 1'b1, 32'hffffffff, 1'b0, 4'h0);
      do_req(1'b0, 3'd4, 32'd415, 32'd0, 1'b1, 1'b1, 32'h000000ff, 1'b0, 4'h0);
      do_req(1'b0, 3'd1, 32'd414, 32'd0, 1'b0, 1'b1, 32'hffffff0f, 1'b0, 4'h0);
      do_req(1'b0, 3'd5, 32'd414, 32'd0, 1'b0, 1'b1, 32'h0000ff0f, 1'b0, 4'h0);
      do_req(1'b0, 3'd2, 32'd412, 32'd0, 1'b0, 1'b1, 32'hff0f0e0d, 1'b0, 4'h0);
      do_req(1'b1, 3'd0, 32'd402, 32'h123456ab, 1'b0, 1'b1, 32'h0, 1'b0, 4'b0100);
      do_req(1'b0, 3'd4, 32'd402, 32'd0, 1'b0, 1'b1, 32'h000000ab, 1'b0, 4'h0);
      do_req(1'b0, 3'd2, 32'd400, 32'd0, 1'b0, 1'b1, 32'h04ab0201, 1'b0, 4'h0);
      do_req(1'b1, 3'd2, 32'd400, 32'hdeadbeef, 1'b1, 1'b1, 32'h0, 1'b0, 4'b1111);
      do_req(1'b0, 3'd2, 32'd400, 32'd0, 1'b1, 1'b1, 32'hdeadbeef, 1'b0, 4'h0);
      do_req(1'b1, 3'd1, 32'd406, 32'h0000beef, 1'b0, 1'b1, 32'h0, 1'b0, 4'b1100);
      do_req(1'b0, 3'd1, 32'd406, 32'd0, 1'b0, 1'b1, 32'hffffbeef, 1'b0, 4'h0);
      do_req(1'b0, 3'd3, 32'd400, 32'd0, 1'b0, 1'b1, 32'h0, 1'b1, 4'h0);
      do_req(1'b1, 3'd4, 32'd400, 32'h55555555, 1'b1, 1'b1, 32'h0, 1'b1, 4'h0);
      do_req(1'b0, 3'd6, 32'd400, 32'd0, 1'b0, 1'b1, 32'h0, 1'b1, 4'h0);

      // Abort a load in DATA with an asynchronous reset.
      suspend = 1'b1;
      @(negedge clk);
      #1;
      req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'd2; req_addr = 32'd412; req_wdata = 32'd0;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      @(negedge clk);
      chk("abort_read_strobe", {31'd0, mem_rstrb}, 32'd1);
      @(negedge clk);
      #1;
      resetn = 1'b0;
      #1;
      chk("abort_ready", {31'd0, req_ready}, 32'd1);
      chk("abort_valid", {31'd0, resp_valid}, 32'd0);
      chk("abort_err", {31'd0, resp_err}, 32'd0);
      chk("abort_rdata", resp_rdata, 32'd0);
      chk("abort_strobes", {27'd0, mem_rstrb, mem_wmask}, 32'd0);
      chk("abort_maddr", mem_addr, 32'd0);
      chk("abort_wdata", mem_wdata, 32'd0);
      repeat (3) begin
         @(negedge clk);
         chk("abort_quiet", {26'd0, resp_valid, mem_rstrb, mem_wmask}, 32'd0);
      end
      #1;
      resetn  = 1'b1;
      suspend = 1'b0;
      do_req(1'b0, 3'd2, 32'd412, 32'd0, 1'b0, 1'b1, 32'hff0f0e0d, 1'b0, 4'h0);
      repeat (2) @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
